key_record_buffer: RTL and testbench

Parametrised keystroke recorder/player for the PS/2 writing machine.
- Stores one-pulse key codes from the keyboard decoder into an internal buffer.
- On enter, replays the stored codes in order, one per paced slot, to the LED/display path.
- Adds over the first-generation recorder: backspace, clear, overflow detection, loop playback and playback abort.

---
 rtl/key_rec_pkg.sv | 19 +
 rtl/key_record_buffer_if.sv | 33 +++
 rtl/key_rec_ram.sv | 28 ++
 rtl/key_record_buffer.sv | 157 +++++++++++++++
 tb/tb_key_record_buffer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_rec_pkg.sv
// rtl/key_rec_pkg.sv - shared types and key code constants for the keystroke recorder
package key_rec_pkg;

    typedef enum logic [1:0] {
        REC  = 2'd0,
        RD   = 2'd1,
        OUT  = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam int CODE_SPACE     = 27;
    localparam int CODE_UNDERLINE = 28;
    localparam int CODE_UP        = 29;
    localparam int CODE_DOWN      = 30;
    localparam int CODE_LEFT      = 31;
    localparam int CODE_RIGHT     = 32;
    localparam int CODE_ENTER     = 34;

endpackage

// File: rtl/key_record_buffer_if.sv
// rtl/key_record_buffer_if.sv - key input / playback output bundle of the recorder
interface key_record_buffer_if #(
    parameter int CODE_W = 6,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              enter;
    logic              backspace;
    logic              clear;
    logic              loop_en;
    logic              play_valid;
    logic [CODE_W-1:0] play_code;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              playing;
    logic              done;

    modport master (
        output key_valid, key_code, enter, backspace, clear, loop_en,
        input  play_valid, play_code, count, full, empty, overflow, playing, done
    );

    modport slave (
        input  key_valid, key_code, enter, backspace, clear, loop_en,
        output play_valid, play_code, count, full, empty, overflow, playing, done
    );

endinterface

// File: rtl/key_rec_ram.sv
// rtl/key_rec_ram.sv - single-port code store, synchronous write and read
module key_rec_ram #(
    parameter int CODE_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                     clk_22,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [CODE_W-1:0]        wdata_i,
    output logic [CODE_W-1:0]        rdata_o
);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] rdata_q;

    // Read data holds between reads so it stays stable through OUT.
    always_ff @(posedge clk_22) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/key_record_buffer.sv
// rtl/key_record_buffer.sv - keystroke recorder with paced, loopable, abortable playback
module key_record_buffer
    import key_rec_pkg::*;
#(
    parameter int CODE_W = 6,
    parameter int DEPTH  = 64,
    parameter int GAP    = 3
) (
    input  logic               clk_22,
    input  logic               rst,
    key_record_buffer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic              full;
    logic              empty;
    logic              advance;
    logic              ram_we;
    logic              ram_re;
    logic [PTR_W-1:0]  ram_addr;
    logic [CODE_W-1:0] ram_rdata;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // count doubles as the write pointer: the next free slot is mem[count].
    assign ram_addr = ram_we ? count_q[PTR_W-1:0] : rd_ptr_q;

    key_rec_ram #(
        .CODE_W(CODE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_22 (clk_22),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(bus.key_code),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk_22) begin
        if (rst) begin
            state_q    <= REC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        gap_d      = gap_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            REC: begin
                if (bus.clear) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (bus.backspace) begin
                    if (!empty) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end else if (bus.key_valid) begin
                    if (!full) begin
                        ram_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (bus.enter && !empty) begin
                    rd_ptr_d = '0;
                    state_d  = RD;
                end
            end
            RD: begin
                ram_re  = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (GAP > 0) begin
                    gap_d   = GAP_LOAD;
                    state_d = WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (gap_q == '0) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = REC;
        endcase

        if (advance) begin
            if (CNT_W'(rd_ptr_q) + CNT_W'(1) < count_q) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                state_d  = RD;
            end else if (bus.loop_en) begin
                rd_ptr_d = '0;
                state_d  = RD;
            end else begin
                done_d     = 1'b1;
                count_d    = '0;
                overflow_d = 1'b0;
                state_d    = REC;
            end
        end

        // An abort overrides any advance decision taken in the same cycle.
        if (state_q != REC && (bus.enter || bus.clear)) begin
            state_d    = REC;
            count_d    = '0;
            overflow_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    assign bus.play_valid = (state_q == OUT);
    assign bus.play_code  = (state_q == OUT) ? ram_rdata : '0;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow_q;
    assign bus.playing    = (state_q != REC);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_key_record_buffer.sv
// tb/tb_key_record_buffer.sv - randomized self-checking bench for key_record_buffer
module tb_key_record_buffer;
    import key_rec_pkg::*;

    localparam int CODE_W = 6;
    localparam int DEPTH  = 64;
    localparam int GAP    = 3;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int P      = GAP + 2;

    logic clk_22 = 1'b0;
    logic rst;

    key_record_buffer_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) kb ();

    key_record_buffer #(.CODE_W(CODE_W), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_22(clk_22),
        .rst   (rst),
        .bus   (kb.slave)
    );

    always #5 clk_22 = ~clk_22;

    int vectors = 0;
    int errors  = 0;
    logic [CODE_W-1:0] q[$];
    bit ovf_m;

    task automatic idle_inputs();
        kb.key_valid = 1'b0;
        kb.key_code  = '0;
        kb.enter     = 1'b0;
        kb.backspace = 1'b0;
        kb.clear     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_22);
        #1;
        idle_inputs();
    endtask

    function automatic logic [CODE_W-1:0] pick_code();
        int tbl[7];
        tbl = '{CODE_SPACE, CODE_UNDERLINE, CODE_UP, CODE_DOWN, CODE_LEFT, CODE_RIGHT, CODE_ENTER};
        if ($urandom_range(0, 3) == 0) return CODE_W'(tbl[$urandom_range(0, 6)]);
        return CODE_W'($urandom_range(0, (1 << CODE_W) - 1));
    endfunction

    // op: 0 idle, 1 key, 2 backspace, 3 backspace+key, 4 clear, 5 enter (only used when empty)
    task automatic rec_op(input int op, input logic [CODE_W-1:0] code);
        bit kv, bs, cl;
        kv = (op == 1 || op == 3);
        bs = (op == 2 || op == 3);
        cl = (op == 4);
        kb.key_valid = kv;
        kb.key_code  = code;
        kb.backspace = bs;
        kb.clear     = cl;
        kb.enter     = (op == 5);
        if (cl) begin
            q.delete();
            ovf_m = 1'b0;
        end else if (bs) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (kv) begin
            if (q.size() < DEPTH) q.push_back(code);
            else ovf_m = 1'b1;
        end
        step();
    endtask

    // Plays back the model queue from an enter pulse; abort_at is the cycle (1 = RD) in which enter/clear aborts.
    task automatic run_playback(input bit loop, input int abort_at, input bit abort_clear, input string tag);
        int n, jend, idx;
        bit live, exp_pv, exp_done;
        logic [CODE_W-1:0] exp_code;
        logic [CNT_W-1:0] exp_cnt;
        n = q.size();
        kb.loop_en = loop;
        kb.enter = 1'b1;
        step();
        jend = (abort_at > 0) ? abort_at + 2 : n * P + 2;
        for (int j = 1; j <= jend; j++) begin
            live     = (abort_at == 0 || j <= abort_at) && (loop || j <= n * P);
            exp_pv   = live && j >= 2 && ((j - 2) % P == 0);
            idx      = (j >= 2) ? ((j - 2) / P) % n : 0;
            exp_code = exp_pv ? q[idx] : '0;
            exp_done = !loop && abort_at == 0 && j == n * P + 1;
            exp_cnt  = live ? CNT_W'(n) : '0;
            vectors++;
            if (kb.play_valid !== exp_pv || kb.play_code !== exp_code || kb.playing !== live ||
                kb.done !== exp_done || kb.count !== exp_cnt || kb.overflow !== (live && ovf_m)) begin
                errors++;
                $display("FAIL %s cycle %0d: pv=%b code=%0d playing=%b done=%b count=%0d ovf=%b, expected pv=%b code=%0d playing=%b done=%b count=%0d ovf=%b",
                         tag, j, kb.play_valid, kb.play_code, kb.playing, kb.done, kb.count, kb.overflow,
                         exp_pv, exp_code, live, exp_done, exp_cnt, live && ovf_m);
            end
            if (j == abort_at) begin
                if (abort_clear) kb.clear = 1'b1;
                else kb.enter = 1'b1;
            end
            if (j < jend) step();
        end
        kb.loop_en = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        kb.loop_en = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        vectors++;
        if (kb.play_valid !== 1'b0 || kb.play_code !== '0 || kb.count !== '0 || kb.empty !== 1'b1 ||
            kb.full !== 1'b0 || kb.overflow !== 1'b0 || kb.playing !== 1'b0 || kb.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: pv=%b code=%0d count=%0d empty=%b full=%b ovf=%b playing=%b done=%b, expected all idle with empty=1",
                     kb.play_valid, kb.play_code, kb.count, kb.empty, kb.full, kb.overflow, kb.playing, kb.done);
        end
    endtask

    task automatic test_record_play();
        rec_op(1, 6'd1);
        rec_op(1, 6'd2);
        rec_op(1, 6'd3);
        vectors++;
        if (kb.count !== CNT_W'(3) || kb.empty !== 1'b0) begin
            errors++;
            $display("FAIL record_count: count=%0d empty=%b, expected 3 and 0", kb.count, kb.empty);
        end
        run_playback(1'b0, 0, 1'b0, "record_play");
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH + 1; i++) rec_op(1, pick_code());
        vectors++;
        if (kb.count !== CNT_W'(DEPTH) || kb.full !== 1'b1 || kb.overflow !== 1'b1 || kb.empty !== 1'b0) begin
            errors++;
            $display("FAIL full_overflow: count=%0d full=%b ovf=%b empty=%b, expected %0d 1 1 0",
                     kb.count, kb.full, kb.overflow, kb.empty, DEPTH);
        end
        run_playback(1'b0, 0, 1'b0, "full_play");
    endtask

    task automatic test_backspace();
        rec_op(1, 6'd5);
        rec_op(1, 6'd6);
        rec_op(2, '0);
        rec_op(1, 6'd7);
        rec_op(3, 6'd9);
        vectors++;
        if (kb.count !== CNT_W'(1) || q.size() != 1 || q[0] !== 6'd5) begin
            errors++;
            $display("FAIL backspace_count: count=%0d, expected 1", kb.count);
        end
        rec_op(1, 6'd7);
        run_playback(1'b0, 0, 1'b0, "backspace_play");
        rec_op(2, '0);
        vectors++;
        if (kb.count !== '0 || kb.empty !== 1'b1) begin
            errors++;
            $display("FAIL backspace_empty: count=%0d empty=%b, expected 0 and 1", kb.count, kb.empty);
        end
    endtask

    task automatic test_empty_enter();
        rec_op(5, '0);
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (kb.playing !== 1'b0 || kb.play_valid !== 1'b0 || kb.done !== 1'b0 || kb.count !== '0) begin
                errors++;
                $display("FAIL empty_enter cycle %0d: playing=%b pv=%b done=%b count=%0d, expected all 0",
                         j, kb.playing, kb.play_valid, kb.done, kb.count);
            end
            step();
        end
    endtask

    task automatic test_loop_abort();
        rec_op(1, 6'd4);
        rec_op(1, 6'd8);
        run_playback(1'b1, 4 * P + 3, 1'b0, "loop_abort");
    endtask

    task automatic test_reset_midplay();
        for (int i = 0; i < 3; i++) rec_op(1, pick_code());
        kb.enter = 1'b1;
        step();
        step();
        vectors++;
        if (kb.play_valid !== 1'b1 || kb.play_code !== q[0]) begin
            errors++;
            $display("FAIL midplay_out: pv=%b code=%0d, expected 1 and %0d", kb.play_valid, kb.play_code, q[0]);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (kb.play_valid !== 1'b0 || kb.playing !== 1'b0 || kb.count !== '0 || kb.empty !== 1'b1 || kb.done !== 1'b0) begin
            errors++;
            $display("FAIL midplay_reset: pv=%b playing=%b count=%0d empty=%b done=%b, expected 0 0 0 1 0",
                     kb.play_valid, kb.playing, kb.count, kb.empty, kb.done);
        end
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        step();
    endtask

    task automatic test_random();
        int nops, r, op, n, abort_at;
        bit loop;
        for (int round = 0; round < 8; round++) begin
            nops = $urandom_range(5, 40);
            for (int k = 0; k < nops; k++) begin
                r = $urandom_range(0, 99);
                if (r < 55) op = 1;
                else if (r < 70) op = 2;
                else if (r < 80) op = (q.size() > 0) ? 3 : 0;
                else if (r < 84) op = 4;
                else if (r < 90) op = (q.size() == 0) ? 5 : 0;
                else op = 0;
                rec_op(op, pick_code());
                vectors++;
                if (kb.count !== CNT_W'(q.size()) || kb.full !== (q.size() == DEPTH) || kb.empty !== (q.size() == 0) ||
                    kb.overflow !== ovf_m || kb.playing !== 1'b0 || kb.play_valid !== 1'b0 || kb.done !== 1'b0) begin
                    errors++;
                    $display("FAIL random_rec round %0d op %0d: count=%0d full=%b empty=%b ovf=%b playing=%b pv=%b done=%b, expected count=%0d ovf=%b idle",
                             round, op, kb.count, kb.full, kb.empty, kb.overflow, kb.playing, kb.play_valid, kb.done,
                             q.size(), ovf_m);
                end
            end
            if (q.size() == 0) rec_op(1, pick_code());
            n = q.size();
            loop = 1'($urandom_range(0, 1));
            if (loop) abort_at = $urandom_range(1, 2 * n * P);
            else abort_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * P) : 0;
            run_playback(loop, abort_at, 1'($urandom_range(0, 1)), "random_play");
        end
    endtask

    initial begin
        test_reset();
        test_record_play();
        test_full_overflow();
        test_backspace();
        test_empty_enter();
        test_loop_abort();
        test_reset_midplay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
